// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - shared constants for the MCU SPI target
package mcu_spi_pkg;

  localparam int SPI_BYTE_W          = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;
  // SCK high/low phases must each last at least this many clk cycles
  localparam int SPI_MIN_HALF_PERIOD = SYNC_STAGES_DEFAULT + 6;

  localparam logic [SPI_BYTE_W-1:0] STATUS_MAGIC0 = 8'h5c;
  localparam logic [SPI_BYTE_W-1:0] STATUS_MAGIC1 = 8'h42;

  function automatic int min_half_period(input int stages);
    return stages + 6;
  endfunction

endpackage

// File: rtl/mcu_spi_target_if.sv
// rtl/mcu_spi_target_if.sv - SPI pins plus decoder byte stream
interface mcu_spi_target_if;
  import mcu_spi_pkg::*;

  logic                  spi_csn;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic                  data_in_strobe;
  logic                  data_in_start;
  logic [SPI_BYTE_W-1:0] data_in;
  logic [SPI_BYTE_W-1:0] data_out;
  logic                  busy;

  modport slave (
    input  spi_csn, spi_sck, spi_mosi, data_out,
    output spi_miso, spi_miso_oe, data_in_strobe, data_in_start, data_in, busy
  );

  modport master (
    output spi_csn, spi_sck, spi_mosi, data_out,
    input  spi_miso, spi_miso_oe, data_in_strobe, data_in_start, data_in, busy
  );

endinterface

// File: rtl/mcu_spi_target_sync_ff.sv
// rtl/mcu_spi_target_sync_ff.sv - multi-stage synchronizer with reset value
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // fewer than two flops is never safe against metastability
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] chain [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) chain[i] <= rst_val;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < N; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/mcu_spi_target.sv
// rtl/mcu_spi_target.sv - oversampled mode-0 SPI target feeding the command decoder
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  mcu_spi_target_if.slave         bus
);

  logic                  cs_s, sck_s, mosi_s, sck_d;
  logic                  rise, fall;
  logic [2:0]            bit_cnt;
  logic                  first;
  logic [6:0]            rx_sr;
  logic [SPI_BYTE_W-1:0] rx_next;
  logic [SPI_BYTE_W-1:0] tx_sr;

  sync_ff #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_val (3'b100),
    .d       ({bus.spi_csn, bus.spi_sck, bus.spi_mosi}),
    .q       ({cs_s, sck_s, mosi_s})
  );

  always_ff @(posedge clk) begin
    if (reset) sck_d <= 1'b0;
    else       sck_d <= sck_s;
  end

  // CS deassertion masks edges, so a rise coinciding with CS going high is dropped
  assign rise    = sck_s & ~sck_d & ~cs_s;
  assign fall    = ~sck_s & sck_d & ~cs_s;
  assign rx_next = {rx_sr, mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt            <= 3'd0;
      first              <= 1'b1;
      rx_sr              <= 7'd0;
      tx_sr              <= '0;
      bus.data_in        <= '0;
      bus.data_in_strobe <= 1'b0;
      bus.data_in_start  <= 1'b0;
    end else begin
      bus.data_in_strobe <= 1'b0;
      bus.data_in_start  <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
        first   <= 1'b1;
        tx_sr   <= '0;
      end else begin
        if (rise) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bus.data_in        <= rx_next;
            bus.data_in_strobe <= 1'b1;
            bus.data_in_start  <= first;
            first              <= 1'b0;
          end
        end
        // response is captured the cycle after the strobe; the byte-boundary fall holds the MSB
        if (bus.data_in_strobe)
          tx_sr <= bus.data_out;
        else if (fall && bit_cnt != 3'd0)
          tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
      end
    end
  end

  assign bus.spi_miso    = ~cs_s & tx_sr[SPI_BYTE_W-1];
  assign bus.spi_miso_oe = ~cs_s;
  assign bus.busy        = ~cs_s;

endmodule
